// File: rtl/riscv_alu_pkg.sv
// rtl/riscv_alu_pkg.sv - op codes, FSM states, flag indices and op-class helpers for the multi-cycle ALU
package riscv_alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_MUL    = 5'h02,
        OP_MULH   = 5'h03,
        OP_MULHSU = 5'h04,
        OP_MULHU  = 5'h05,
        OP_DIV    = 5'h06,
        OP_DIVU   = 5'h07,
        OP_REM    = 5'h08,
        OP_REMU   = 5'h09,
        OP_XOR    = 5'h0A,
        OP_OR     = 5'h0B,
        OP_AND    = 5'h0C,
        OP_SLL    = 5'h0D,
        OP_SRL    = 5'h0E,
        OP_SRA    = 5'h0F,
        OP_SLT    = 5'h10,
        OP_SLTU   = 5'h11,
        OP_SEQ    = 5'h12,
        OP_SNE    = 5'h13
    } alu_op_e;

    localparam logic [4:0] ILLEGAL_OP_BASE = 5'h14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    function automatic logic is_mul(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_MULHU);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/riscv_alu_divider.sv
// rtl/riscv_alu_divider.sv - iterative unsigned restoring divider, one quotient bit per cycle
module riscv_alu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q;
    logic [XLEN:0]   shifted, diff;

    // A negative trial difference means the divisor did not fit: restore.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dsr_q};
        if (diff[XLEN]) begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
                rem_q  <= '0;
                quo_q  <= dividend_i;
                dsr_q  <= divisor_i;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/riscv_alu_mc.sv
// rtl/riscv_alu_mc.sv - multi-cycle RV32IM/RV64IM execute ALU; RISCV_ALU_DIV_EARLY_EXIT_EN enables short divides
module riscv_alu_mc #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic             out_illegal
);
    import riscv_alu_pkg::*;

    localparam int SHW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [TAG_W-1:0]  tag_q;
    logic              out_valid_q, out_illegal_q;
    logic [XLEN-1:0]   out_result_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic [3:0]        out_flags_q;

    logic              accept, early, in_signed, div_signed, sa, sb;
    logic              load, load_illegal;
    logic [XLEN-1:0]   load_result;
    logic [TAG_W-1:0]  load_tag;
    logic [3:0]        load_flags;
    logic [XLEN:0]     add_sum, sub_sum;
    logic [XLEN-1:0]   simple_res, mul_res, div_res;
    logic              simple_carry, simple_ovf;
    logic [2*XLEN-1:0] ax, bx, prod;
    logic              div_start, div_busy, div_done;
    logic [XLEN-1:0]   div_a_mag, div_b_mag, div_quo, div_rem;

    always_comb begin
        add_sum      = {1'b0, in_a} + {1'b0, in_b};
        sub_sum      = {1'b0, in_a} + {1'b0, ~in_b} + {{XLEN{1'b0}}, 1'b1};
        simple_res   = '0;
        simple_carry = 1'b0;
        simple_ovf   = 1'b0;
        case (in_op)
            OP_ADD: begin
                simple_res   = add_sum[XLEN-1:0];
                simple_carry = add_sum[XLEN];
                simple_ovf   = (in_a[XLEN-1] == in_b[XLEN-1]) && (add_sum[XLEN-1] != in_a[XLEN-1]);
            end
            OP_SUB: begin
                simple_res   = sub_sum[XLEN-1:0];
                simple_carry = sub_sum[XLEN];
                simple_ovf   = (in_a[XLEN-1] != in_b[XLEN-1]) && (sub_sum[XLEN-1] != in_a[XLEN-1]);
            end
            OP_XOR:  simple_res = in_a ^ in_b;
            OP_OR:   simple_res = in_a | in_b;
            OP_AND:  simple_res = in_a & in_b;
            OP_SLL:  simple_res = in_a << in_b[SHW-1:0];
            OP_SRL:  simple_res = in_a >> in_b[SHW-1:0];
            OP_SRA:  simple_res = $signed(in_a) >>> in_b[SHW-1:0];
            OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, in_a < in_b};
            OP_SEQ:  simple_res = {{(XLEN-1){1'b0}}, in_a == in_b};
            OP_SNE:  simple_res = {{(XLEN-1){1'b0}}, in_a != in_b};
            default: simple_res = '0;
        endcase
    end

    // Sign-extend to 2*XLEN so one unsigned multiply yields every MUL variant.
    always_comb begin
        sa      = (op_q == OP_MULH) || (op_q == OP_MULHSU);
        sb      = (op_q == OP_MULH);
        ax      = {{XLEN{sa & a_q[XLEN-1]}}, a_q};
        bx      = {{XLEN{sb & b_q[XLEN-1]}}, b_q};
        prod    = ax * bx;
        mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef RISCV_ALU_DIV_EARLY_EXIT_EN
        if (is_div(op_q)) begin
            if ((op_q == OP_DIV) || (op_q == OP_DIVU)) mul_res = (b_q == '0) ? '1 : '0;
            else                                       mul_res = a_q;
        end
`endif
    end

    always_comb begin
        in_signed = (in_op == OP_DIV) || (in_op == OP_REM);
        div_a_mag = (in_signed && in_a[XLEN-1]) ? -in_a : in_a;
        div_b_mag = (in_signed && in_b[XLEN-1]) ? -in_b : in_b;
`ifdef RISCV_ALU_DIV_EARLY_EXIT_EN
        early     = (in_b == '0) || (div_b_mag > div_a_mag);
`else
        early     = 1'b0;
`endif
        div_start = accept && is_div(in_op) && !early;
    end

    riscv_alu_divider #(.XLEN(XLEN)) u_divider (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (div_start),
        .dividend_i  (div_a_mag),
        .divisor_i   (div_b_mag),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Signs reapplied to the magnitudes; divide-by-zero overrides the raw divider output.
    always_comb begin
        div_signed = (op_q == OP_DIV) || (op_q == OP_REM);
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            div_res = (div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_quo : div_quo;
            if (b_q == '0) div_res = '1;
        end else begin
            div_res = (div_signed && a_q[XLEN-1]) ? -div_rem : div_rem;
            if (b_q == '0) div_res = a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul(in_op) || (is_div(in_op) && early)) state_d = ST_MUL;
                    else if (is_div(in_op))                        state_d = ST_DIV;
                end
            end
            ST_MUL:  state_d = ST_IDLE;
            ST_DIV:  if (div_done && !div_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        accept       = in_valid && in_ready;
        load         = 1'b0;
        load_result  = '0;
        load_tag     = tag_q;
        load_illegal = 1'b0;
        load_flags   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept && !is_mul(in_op) && !is_div(in_op)) begin
                    load     = 1'b1;
                    load_tag = in_tag;
                    if (in_op >= ILLEGAL_OP_BASE) begin
                        load_illegal = 1'b1;
                    end else begin
                        load_result           = simple_res;
                        load_flags[FLAG_CARRY] = simple_carry;
                        load_flags[FLAG_OVF]   = simple_ovf;
                    end
                end
            end
            ST_MUL: begin
                load        = 1'b1;
                load_result = mul_res;
            end
            ST_DIV: begin
                load        = div_done;
                load_result = div_res;
            end
            default: load = 1'b0;
        endcase
        load_flags[FLAG_ZERO] = !load_illegal && (load_result == '0);
        load_flags[FLAG_NEG]  = !load_illegal && load_result[XLEN-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            tag_q         <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_tag_q     <= '0;
            out_flags_q   <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= in_op;
                a_q   <= in_a;
                b_q   <= in_b;
                tag_q <= in_tag;
            end
            if (load) begin
                out_valid_q   <= 1'b1;
                out_result_q  <= load_result;
                out_tag_q     <= load_tag;
                out_flags_q   <= load_flags;
                out_illegal_q <= load_illegal;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_tag     = out_tag_q;
    assign out_flags   = out_flags_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_riscv_alu_mc.sv
// tb/tb_riscv_alu_mc.sv - randomized scoreboard bench for riscv_alu_mc against an arithmetic reference model
module tb_riscv_alu_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic [3:0]  out_flags;
    logic        out_illegal;

    riscv_alu_mc #(.XLEN(32), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_flags(out_flags), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic        ill;
        logic [3:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          busy_until = 0;
    int          stall_cycles = 0;
    bit          rand_rdy = 1'b0;
    logic [3:0]  tag_ctr = '0;
    bit          held = 1'b0;
    logic [31:0] prev_res;
    logic [3:0]  prev_tag, prev_flags;
    logic        prev_ill;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output logic ill);
        longint sa, sb, ua, ub, t;
        logic [63:0] p;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op)
            5'h00: begin t = sa + sb; r = a + b; c = ((ua + ub) >> 32) != 0;
                         v = (t != longint'($signed(32'(t)))); end
            5'h01: begin t = sa - sb; r = a - b; c = (a >= b);
                         v = (t != longint'($signed(32'(t)))); end
            5'h02: r = 32'(sa * sb);
            5'h03: begin p = sa * sb; r = p[63:32]; end
            5'h04: begin p = sa * ub; r = p[63:32]; end
            5'h05: begin p = ua * ub; r = p[63:32]; end
            5'h06: r = (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
            5'h07: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            5'h08: r = (b == 0) ? a : 32'(sa % sb);
            5'h09: r = (b == 0) ? a : a % b;
            5'h0A: r = a ^ b;
            5'h0B: r = a | b;
            5'h0C: r = a & b;
            5'h0D: r = a << b[4:0];
            5'h0E: r = a >> b[4:0];
            5'h0F: r = 32'(sa >>> b[4:0]);
            5'h10: r = {31'd0, sa < sb};
            5'h11: r = {31'd0, a < b};
            5'h12: r = {31'd0, a == b};
            5'h13: r = {31'd0, a != b};
            default: ill = 1'b1;
        endcase
        f = ill ? 4'b0000 : {v, c, r[31], r == 32'd0};
    endfunction

    function automatic int lat_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 5'h02 && op <= 5'h05) return 2;
        if (op >= 5'h06 && op <= 5'h09) begin
`ifdef RISCV_ALU_DIV_EARLY_EXIT_EN
            longint ma, mb;
            bit sgn;
            sgn = (op == 5'h06) || (op == 5'h08);
            ma = longint'({32'd0, a});
            mb = longint'({32'd0, b});
            if (sgn) begin
                ma = longint'($signed(a)); if (ma < 0) ma = -ma;
                mb = longint'($signed(b)); if (mb < 0) mb = -mb;
            end
            if (b == 0 || mb > ma) return 2;
`endif
            return 34;
        end
        return 1;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            busy_until = 0;
            held = 1'b0;
        end else begin
            chk("in_ready", in_ready, (cyc >= busy_until) && (!out_valid || out_ready));
            if (out_valid) begin
                if (held) begin
                    chk("hold_result", out_result, prev_res);
                    chk("hold_tag", out_tag, prev_tag);
                    chk("hold_flags", out_flags, prev_flags);
                    chk("hold_illegal", out_illegal, prev_ill);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                end
                if (out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("result", out_result, e.r);
                    chk("flags", out_flags, e.f);
                    chk("illegal", out_illegal, e.ill);
                    chk("tag", out_tag, e.tag);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].acc + exp_q[0].lat) begin
                chk("result_late", out_valid, 1'b1);
                void'(exp_q.pop_front());
            end
            held = out_valid && !out_ready;
            prev_res = out_result; prev_tag = out_tag; prev_flags = out_flags; prev_ill = out_illegal;
            if (in_valid && in_ready) begin
                model(in_op, in_a, in_b, e.r, e.f, e.ill);
                e.tag = in_tag;
                e.acc = cyc;
                e.lat = lat_of(in_op, in_a, in_b);
                exp_q.push_back(e);
                busy_until = cyc + e.lat;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_cycles > 0) begin
                out_ready = 1'b0;
                stall_cycles--;
            end else if (rand_rdy) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Entered and left at posedge+1 so consecutive calls issue back to back.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag_ctr;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 300) chk("accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        if (n == 300) chk("drain_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic        ill;

        model(5'h00, 32'hFFFFFFFF, 32'h1, r, f, ill);
        chk("model_add_wrap", {r, f}, {32'h0, 4'b0101});
        model(5'h00, 32'h7FFFFFFF, 32'h1, r, f, ill);
        chk("model_add_ovf", {r, f}, {32'h80000000, 4'b1010});
        model(5'h01, 32'd5, 32'd7, r, f, ill);
        chk("model_sub_neg", {r, f}, {32'hFFFFFFFE, 4'b0010});
        model(5'h03, 32'h80000000, 32'h80000000, r, f, ill);
        chk("model_mulh", r, 32'h40000000);
        model(5'h05, 32'hFFFFFFFF, 32'hFFFFFFFF, r, f, ill);
        chk("model_mulhu", r, 32'hFFFFFFFE);
        model(5'h06, 32'h80000000, 32'hFFFFFFFF, r, f, ill);
        chk("model_div_ovf", {r, f}, {32'h80000000, 4'b0010});
        model(5'h08, 32'h80000000, 32'hFFFFFFFF, r, f, ill);
        chk("model_rem_ovf", {r, f}, {32'h0, 4'b0001});
        model(5'h07, 32'd7, 32'd0, r, f, ill);
        chk("model_divu_zero", r, 32'hFFFFFFFF);
        model(5'h09, 32'd7, 32'd0, r, f, ill);
        chk("model_remu_zero", r, 32'd7);
        model(5'h15, 32'd3, 32'd4, r, f, ill);
        chk("model_illegal", {r, f, 3'b000, ill}, {32'h0, 4'b0000, 4'b0001});
        chk("model_div_latency", lat_of(5'h07, 32'd100, 32'd3), 34);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", out_result, 32'h0);
        chk("rst_tag", out_tag, 4'h0);
        chk("rst_flags", out_flags, 4'h0);
        chk("rst_illegal", out_illegal, 1'b0);
        @(posedge clk); #1;

        send(5'h00, 32'hFFFFFFFF, 32'h1);
        send(5'h00, 32'h7FFFFFFF, 32'h1);
        send(5'h01, 32'd5, 32'd7);
        send(5'h03, 32'h80000000, 32'h80000000);
        send(5'h05, 32'hFFFFFFFF, 32'hFFFFFFFF);
        send(5'h06, 32'h80000000, 32'hFFFFFFFF);
        send(5'h08, 32'h80000000, 32'hFFFFFFFF);
        send(5'h07, 32'd7, 32'd0);
        send(5'h09, 32'd7, 32'd0);
        send(5'h15, 32'd3, 32'd4);
        send(5'h0F, 32'h80000010, 32'd36);
        wait_idle();

        stall_cycles = 4;
        send(5'h0A, 32'hA5A5A5A5, 32'h0F0F0F0F);
        send(5'h0A, 32'h12345678, 32'hFFFF0000);
        send(5'h0A, 32'h0, 32'h0);
        wait_idle();

        send(5'h06, 32'hDEADBEEF, 32'd13);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_div_reset_out_valid", out_valid, 1'b0);
        chk("mid_div_reset_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        repeat (40) @(posedge clk);
        #1;

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
            send(op, rand_operand(), rand_operand());
        end
        rand_rdy = 1'b0;
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
